rob_commit_sched: RTL and testbench
===================================

# rob_commit_sched

In-order commit scheduler for the writeback/commit unit. It allocates sequence numbers to decode in program order and tracks completion of each in-flight sequence number. It emits exactly one commit per cycle, oldest first, to drive the ROB dequeue and the commit notification. It owns the head/tail pointers and per-entry state that the ROB and the sequence-number arbiter rely on.

## Interface
Parameters:
- p_seq_num_bits, 5, sequence-number width; window depth D = 2**p_seq_num_bits

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- alloc_en  in  1  decode takes alloc_seq_num this cycle; legal only when alloc_rdy
- alloc_rdy  out  1  window not full
- alloc_seq_num  out  p_seq_num_bits  next sequence number to hand out (tail)
- complete_val  in  1  an instruction completed (complete notification valid)
- complete_seq_num  in  p_seq_num_bits  sequence number of completing instruction
- commit_val  out  1  head entry commits this cycle (drives ROB deq_en and commit val)
- commit_seq_num  out  p_seq_num_bits  sequence number being committed (head)
- count  out  p_seq_num_bits+1  entries allocated and not yet committed, 0..D
- empty  out  1  count == 0
- err  out  1  sticky protocol-error flag

## Operation
- State: head, tail (p_seq_num_bits, wrap mod D), count (p_seq_num_bits+1), per-entry alloc[D] and done[D].
- alloc_rdy = (count != D), from registered count only. No same-cycle bypass from a commit.
- alloc_seq_num = tail.
- Allocate (alloc_en & alloc_rdy):
  - alloc[tail] <= 1, done[tail] <= 0
  - tail <= tail+1, wrapping from D-1 to 0
- alloc_en while !alloc_rdy: ignored, err <= 1.
- Complete (complete_val):
  - If alloc[complete_seq_num] & !done[complete_seq_num]: done[...] <= 1.
  - Otherwise (unallocated entry, or double completion): no state change, err <= 1.
- commit_val = (count != 0) & done[head]. Combinational from registered state.
- commit_seq_num = head.
- Commit (commit_val): alloc[head] <= 0, done[head] <= 0, head <= head+1 with wrap. No backpressure; commit always proceeds.
- count next = count + (alloc accepted) - commit_val. Simultaneous alloc and commit leaves count unchanged.
- Same-cycle complete and commit of the same seq_num cannot occur, because commit needs done already set.
- Same-cycle complete and alloc to different entries: both apply.
- err stays set until reset.

## Timing
- Reset values:
  - head = tail = 0, count = 0, all alloc/done = 0
  - alloc_rdy = 1, alloc_seq_num = 0
  - commit_val = 0, commit_seq_num = 0
  - empty = 1, err = 0
- Alloc to complete: an entry allocated at cycle t accepts completion from cycle t+1 onward.
- Complete to commit latency: complete at cycle t, head matches, gives commit_val at t+1. This matches the one-cycle insertion register in front of the ROB, so the ROB entry is written when commit reads it.
- Throughput: one alloc and one commit per cycle, sustained.
- Full (count == D):
  - alloc_rdy = 0 even if commit_val is high this cycle
  - alloc_rdy rises the cycle after the commit
- Empty: commit_val = 0 regardless of stale done bits.
- Wrap-around: head and tail wrap independently; full versus empty is resolved by count, never by head == tail.
- Reset mid-operation: all in-flight entries are discarded; the next allocation gets seq_num 0.

## Structure
- Shared package: D derivation and the count-width constant, plus an entry-state struct (alloc, done), so the ROB and SeqArb can share the window definition.
- One natural sub-module: seq_ptr, a wrapping p_seq_num_bits counter with increment enable and synchronous reset. Instantiate it twice, for head and tail.
- Per-entry state lives in flops, not RAM, because the random-access completion write must coexist with the head read.

## Test plan
- Reset, then hold idle 3 cycles -> alloc_rdy = 1, alloc_seq_num = 0, commit_val = 0, empty = 1, err = 0.
- Allocate 0,1,2; complete 2, then 1, then 0 on consecutive cycles -> no commit until the cycle after completing 0; then commit_seq_num 0,1,2 on three consecutive cycles; count returns to 0.
- p_seq_num_bits = 2: allocate 4 entries -> count = 4, alloc_rdy = 0. Complete 0, then alloc_en in the commit cycle -> alloc rejected, err = 1. Alloc accepted next cycle with alloc_seq_num 0 (wrap).
- Streaming: every cycle allocate N and complete N-1, for 40 cycles with D = 32 -> one commit per cycle after warm-up, seq_num wraps 31 -> 0 with no gap, count stays at 2.
- Complete seq_num 5 when never allocated, then complete an allocated seq_num twice -> no done change; err = 1 after the first fault and stays 1.
- Assert rst with 6 entries in flight, 3 of them done -> the next cycle shows count = 0 and commit_val = 0, and the next alloc gets seq_num 0.

Source files
------------

// File: rtl/rob_commit_sched_pkg.sv
// Shared window definition for the in-order commit scheduler, the ROB and
// the sequence-number arbiter.
//   depth()       : window depth D = 2**seq_num_bits
//   count_width() : width of an occupancy count covering 0..D inclusive
//   entry_t       : per-entry tracking state (allocated, completed)
package rob_commit_sched_pkg;

  localparam int SEQ_NUM_BITS_DFLT = 5;

  function automatic int depth(input int seq_num_bits);
    return 1 << seq_num_bits;
  endfunction

  // One extra bit so a completely full window (count == D) is representable.
  function automatic int count_width(input int seq_num_bits);
    return seq_num_bits + 1;
  endfunction

  typedef struct packed {
    logic alloc;
    logic done;
  } entry_t;

endpackage

// File: rtl/rob_commit_sched_seq_ptr.sv
// Wrapping sequence-number pointer: counts modulo 2**p_bits when inc_en_i
// is high. Used for both the head (commit) and tail (allocate) pointers.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset, returns the pointer to 0
//   inc_en_i : advance the pointer by one this cycle
//   ptr_o    : current (registered) pointer value
module rob_commit_sched_seq_ptr #(
  parameter int p_bits = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en_i,
  output logic [p_bits-1:0] ptr_o
);

  logic [p_bits-1:0] ptr_q;
  logic [p_bits-1:0] ptr_d;

  // Natural overflow of the p_bits-wide add gives the D-1 -> 0 wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_en_i) ptr_d = ptr_q + p_bits'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_sched.sv
// In-order commit scheduler. Hands out sequence numbers in program order
// (tail), records completions against any in-flight entry, and commits the
// oldest entry (head) once it is done, at most one commit per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   alloc_en          : decode consumes alloc_seq_num (legal only if alloc_rdy)
//   alloc_rdy         : window not full (registered count only)
//   alloc_seq_num     : next sequence number to hand out
//   complete_val      : completion notification valid
//   complete_seq_num  : sequence number that completed
//   commit_val        : head entry commits this cycle
//   commit_seq_num    : sequence number at the head
//   count             : in-flight entries, 0..D
//   empty             : count == 0
//   err               : sticky protocol error (alloc when full, bad completion)
module rob_commit_sched #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  output logic                      commit_val,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [p_seq_num_bits:0]   count,
  output logic                      empty,
  output logic                      err
);

  import rob_commit_sched_pkg::*;

  localparam int D  = depth(p_seq_num_bits);
  localparam int CW = count_width(p_seq_num_bits);
  localparam logic [CW-1:0] FULL_C = CW'(D);

  logic [p_seq_num_bits-1:0] head_q;
  logic [p_seq_num_bits-1:0] tail_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  entry_t                    entry_q [D];
  entry_t                    entry_d [D];
  logic                      err_q;
  logic                      err_d;

  logic alloc_acc;
  logic complete_ok;

  rob_commit_sched_seq_ptr #(.p_bits(p_seq_num_bits)) u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (commit_val),
    .ptr_o    (head_q)
  );

  rob_commit_sched_seq_ptr #(.p_bits(p_seq_num_bits)) u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (alloc_acc),
    .ptr_o    (tail_q)
  );

  // Full/empty come from count alone; head == tail is ambiguous.
  assign alloc_rdy      = (count_q != FULL_C);
  assign alloc_seq_num  = tail_q;
  assign alloc_acc      = alloc_en && alloc_rdy;

  // The count guard masks stale done bits when the window is empty.
  assign commit_val     = (count_q != '0) && entry_q[head_q].done;
  assign commit_seq_num = head_q;

  assign complete_ok    = entry_q[complete_seq_num].alloc &&
                          !entry_q[complete_seq_num].done;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign err   = err_q;

  // Commit, allocate and complete never target the same entry in one cycle:
  // head == tail with an accepted alloc implies an empty window (no commit),
  // and a completion can only hit an entry that is allocated and not done,
  // which excludes both the committing head and the newly allocated tail.
  always_comb begin
    entry_d = entry_q;
    if (commit_val) entry_d[head_q] = '{alloc: 1'b0, done: 1'b0};
    if (alloc_acc)  entry_d[tail_q] = '{alloc: 1'b1, done: 1'b0};
    if (complete_val && complete_ok) entry_d[complete_seq_num].done = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (alloc_acc && !commit_val)      count_d = count_q + CW'(1);
    else if (!alloc_acc && commit_val) count_d = count_q - CW'(1);
  end

  assign err_d = err_q
               || (alloc_en && !alloc_rdy)
               || (complete_val && !complete_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) entry_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rob_commit_sched.sv
// Bench for rob_commit_sched: a queue-based program-order model checked every
// cycle, plus hand-computed literal expectations. Two instances are built
// (5-bit and 2-bit sequence numbers); sel chooses which one the model tracks.
module tb_rob_commit_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       alloc_en;
  logic       complete_val;
  logic [4:0] complete_seq_num;

  logic       a5_rdy, c5_val, emp5, err5;
  logic [4:0] a5_seq, c5_seq;
  logic [5:0] cnt5;

  logic       a2_rdy, c2_val, emp2, err2;
  logic [1:0] a2_seq, c2_seq;
  logic [2:0] cnt2;

  rob_commit_sched #(.p_seq_num_bits(5)) dut5 (
    .clk              (clk),
    .rst              (rst),
    .alloc_en         (alloc_en),
    .alloc_rdy        (a5_rdy),
    .alloc_seq_num    (a5_seq),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num),
    .commit_val       (c5_val),
    .commit_seq_num   (c5_seq),
    .count            (cnt5),
    .empty            (emp5),
    .err              (err5)
  );

  rob_commit_sched #(.p_seq_num_bits(2)) dut2 (
    .clk              (clk),
    .rst              (rst),
    .alloc_en         (alloc_en),
    .alloc_rdy        (a2_rdy),
    .alloc_seq_num    (a2_seq),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num[1:0]),
    .commit_val       (c2_val),
    .commit_seq_num   (c2_seq),
    .count            (cnt2),
    .empty            (emp2),
    .err              (err2)
  );

  bit sel    = 1'b0;
  bit chk_en = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outputs of whichever instance the model follows.
  logic       a_rdy, a_cv, a_emp, a_err;
  logic [4:0] a_aseq, a_cseq;
  logic [5:0] a_cnt;
  always_comb begin
    a_rdy  = sel ? a2_rdy : a5_rdy;
    a_cv   = sel ? c2_val : c5_val;
    a_emp  = sel ? emp2   : emp5;
    a_err  = sel ? err2   : err5;
    a_aseq = sel ? {3'b000, a2_seq} : a5_seq;
    a_cseq = sel ? {3'b000, c2_seq} : c5_seq;
    a_cnt  = sel ? {3'b000, cnt2}   : cnt5;
  end

  // Model: in-flight instructions in program order, oldest at the front.
  typedef struct {
    int seq;
    bit done;
  } ment_t;
  ment_t mq[$];
  int    m_tail = 0;
  bit    m_err  = 1'b0;
  int    md     = 32;

  always @(posedge clk) begin : model_upd
    int cs;
    bit cv;
    bit rdy;
    bit found;
    md = sel ? 4 : 32;
    if (rst) begin
      mq.delete();
      m_tail = 0;
      m_err  = 1'b0;
    end else begin
      cv  = (mq.size() > 0) && mq[0].done;
      rdy = (mq.size() != md);
      if (complete_val) begin
        cs    = int'(complete_seq_num) % md;
        found = 1'b0;
        foreach (mq[i]) begin
          if (mq[i].seq == cs) begin
            found = 1'b1;
            if (mq[i].done) m_err = 1'b1;
            else            mq[i].done = 1'b1;
          end
        end
        if (!found) m_err = 1'b1;
      end
      if (cv) void'(mq.pop_front());
      if (alloc_en) begin
        if (rdy) begin
          mq.push_back('{seq: m_tail, done: 1'b0});
          m_tail = (m_tail + 1) % md;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model alloc_rdy",      a_rdy,  (mq.size() != md));
      chk("model alloc_seq_num",  a_aseq, m_tail);
      chk("model commit_val",     a_cv,   (mq.size() > 0) && mq[0].done);
      chk("model commit_seq_num", a_cseq, (mq.size() > 0) ? mq[0].seq : m_tail);
      chk("model count",          a_cnt,  mq.size());
      chk("model empty",          a_emp,  (mq.size() == 0));
      chk("model err",            a_err,  m_err);
    end
  end

  task automatic cyc(input bit a, input bit c, input int cs);
    alloc_en         = a;
    complete_val     = c;
    complete_seq_num = 5'(cs);
    @(posedge clk);
    #1;
    alloc_en         = 1'b0;
    complete_val     = 1'b0;
    complete_seq_num = '0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_en = 1'b0;
    complete_val = 1'b0;
    complete_seq_num = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (3) cyc(0, 0, 0);
    chk("lit idle alloc_rdy", a5_rdy, 1);
    chk("lit idle alloc_seq", a5_seq, 0);
    chk("lit idle commit_val", c5_val, 0);
    chk("lit idle empty", emp5, 1);
    chk("lit idle err", err5, 0);

    // Out-of-order completion, in-order commit
    repeat (3) cyc(1, 0, 0);
    chk("lit ooo count3", cnt5, 3);
    chk("lit ooo alloc_seq", a5_seq, 3);
    cyc(0, 1, 2);
    chk("lit ooo no commit a", c5_val, 0);
    cyc(0, 1, 1);
    chk("lit ooo no commit b", c5_val, 0);
    cyc(0, 1, 0);
    chk("lit ooo commit0 val", c5_val, 1);
    chk("lit ooo commit0 seq", c5_seq, 0);
    cyc(0, 0, 0);
    chk("lit ooo commit1 val", c5_val, 1);
    chk("lit ooo commit1 seq", c5_seq, 1);
    cyc(0, 0, 0);
    chk("lit ooo commit2 val", c5_val, 1);
    chk("lit ooo commit2 seq", c5_seq, 2);
    cyc(0, 0, 0);
    chk("lit ooo drained count", cnt5, 0);
    chk("lit ooo drained cv", c5_val, 0);

    // Streaming through the 31 -> 0 wrap
    for (int k = 0; k < 40; k++) begin
      cyc(1, k > 0, (3 + k + 31) % 32);
      if (k >= 1) begin
        chk("lit stream count", cnt5, 2);
        chk("lit stream commit_val", c5_val, 1);
        chk("lit stream commit_seq", c5_seq, (3 + k - 1) % 32);
      end
    end
    cyc(0, 1, 10);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("lit stream drained", cnt5, 0);
    chk("lit stream tail", a5_seq, 11);
    chk("lit stream err", err5, 0);

    // Protocol errors: unallocated completion, double completion
    cyc(0, 1, 5);
    chk("lit err unalloc", err5, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 12);
    cyc(0, 1, 12);
    chk("lit err double sticky", err5, 1);
    chk("lit err double cv", c5_val, 0);
    chk("lit err double count", cnt5, 2);
    cyc(0, 1, 11);
    chk("lit err commit11", c5_seq, 11);
    cyc(0, 0, 0);
    chk("lit err 12 still done", c5_val, 1);
    chk("lit err commit12", c5_seq, 12);
    cyc(0, 0, 0);
    chk("lit err empty", emp5, 1);
    chk("lit err still set", err5, 1);

    // Reset with work in flight
    repeat (6) cyc(1, 0, 0);
    cyc(0, 1, 14);
    cyc(0, 1, 15);
    cyc(0, 1, 16);
    chk("lit rst pre count", cnt5, 6);
    chk("lit rst pre cv", c5_val, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("lit rst count", cnt5, 0);
    chk("lit rst cv", c5_val, 0);
    chk("lit rst err", err5, 0);
    chk("lit rst alloc_seq", a5_seq, 0);
    cyc(1, 0, 0);
    chk("lit rst next alloc", a5_seq, 1);
    chk("lit rst next count", cnt5, 1);
    chk("lit rst head", c5_seq, 0);

    // Small window: full behaviour and tail wrap
    chk_en = 1'b0;
    sel = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (4) cyc(1, 0, 0);
    chk("lit full count", cnt2, 4);
    chk("lit full rdy", a2_rdy, 0);
    chk("lit full tail", a2_seq, 0);
    cyc(0, 1, 0);
    chk("lit full cv", c2_val, 1);
    chk("lit full rdy while commit", a2_rdy, 0);
    cyc(1, 0, 0);
    chk("lit full rejected err", err2, 1);
    chk("lit full count3", cnt2, 3);
    chk("lit full rdy back", a2_rdy, 1);
    chk("lit full wrap seq", a2_seq, 0);
    cyc(1, 0, 0);
    chk("lit full accepted count", cnt2, 4);
    chk("lit full accepted tail", a2_seq, 1);
    chk("lit full head", c2_seq, 1);
    chk("lit full err sticky", err2, 1);
    cyc(0, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
